// File: rtl/reg_writeback.sv
// Write-back queue: buffers register-file writes in order and exposes them to decode through a bypass port.
// Latency 1 cycle from accept to wb_*; in_ready drops when DEPTH entries are queued; the head entry holds until wb_ack.
module reg_writeback #(
  parameter int WORD  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reg_write_in,
  input  logic             mem_to_reg,
  input  logic [4:0]       dest_reg,
  input  logic [WORD-1:0]  alu_result,
  input  logic [WORD-1:0]  mem_data,
  output logic             wb_reg_write,
  output logic [4:0]       wb_register,
  output logic [WORD-1:0]  wb_data,
  input  logic             wb_ack,
  input  logic [4:0]       byp_reg,
  output logic             byp_hit,
  output logic [WORD-1:0]  byp_data,
  output logic [2:0]       pending,
  output logic [CNT_W-1:0] retired
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       q_reg [DEPTH];
  logic [WORD-1:0]  q_dat [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [2:0]       count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign in_ready = (count < 3'(DEPTH));
  // XZR writes and non-writing results are consumed here so they never occupy a slot
  assign push     = in_valid & in_ready & reg_write_in & (dest_reg != 5'd31);
  assign pop      = wb_ack & wb_reg_write;

  assign pending      = count;
  assign wb_reg_write = (count != 3'd0);
  assign wb_register  = wb_reg_write ? q_reg[head] : 5'd0;
  assign wb_data      = wb_reg_write ? q_dat[head] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i] <= '0;
        q_dat[i] <= '0;
      end
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      retired <= '0;
    end else begin
      if (push) begin
        q_reg[tail] <= dest_reg;
        q_dat[tail] <= mem_to_reg ? mem_data : alu_result;
        tail        <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
        if (retired != {CNT_W{1'b1}}) retired <= retired + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    byp_hit  = 1'b0;
    byp_data = '0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = {1'b0, head} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(DEPTH)) sum = sum - (PTR_W + 1)'(DEPTH);
      idx = sum[PTR_W-1:0];
      if ((3'(i) < count) && (q_reg[idx] == byp_reg) && (byp_reg != 5'd31)) begin
        byp_hit  = 1'b1;
        byp_data = q_dat[idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios with literal expectations, then random traffic against a queue model.
module tb_reg_writeback;
  localparam int WORD  = 64;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, reg_write_in, mem_to_reg;
  logic [4:0]       dest_reg;
  logic [WORD-1:0]  alu_result, mem_data;
  logic             wb_reg_write;
  logic [4:0]       wb_register;
  logic [WORD-1:0]  wb_data;
  logic             wb_ack;
  logic [4:0]       byp_reg;
  logic             byp_hit;
  logic [WORD-1:0]  byp_data;
  logic [2:0]       pending;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  reg_writeback #(.WORD(WORD), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_in(reg_write_in), .mem_to_reg(mem_to_reg), .dest_reg(dest_reg),
    .alu_result(alu_result), .mem_data(mem_data), .wb_reg_write(wb_reg_write),
    .wb_register(wb_register), .wb_data(wb_data), .wb_ack(wb_ack),
    .byp_reg(byp_reg), .byp_hit(byp_hit), .byp_data(byp_data),
    .pending(pending), .retired(retired)
  );

  typedef struct packed {
    logic [4:0]      r;
    logic [WORD-1:0] d;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_ret;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the queue
  task automatic check_all();
    logic            e_hit;
    logic [WORD-1:0] e_byp;
    e_hit = 1'b0;
    e_byp = '0;
    foreach (mq[i]) begin
      if (mq[i].r == byp_reg && byp_reg != 5'd31) begin
        e_hit = 1'b1;
        e_byp = mq[i].d;
      end
    end
    chk("in_ready",     64'(in_ready),     64'(mq.size() < DEPTH));
    chk("wb_reg_write", 64'(wb_reg_write), 64'(mq.size() > 0));
    chk("wb_register",  64'(wb_register),  (mq.size() > 0) ? 64'(mq[0].r) : 64'd0);
    chk("wb_data",      64'(wb_data),      (mq.size() > 0) ? 64'(mq[0].d) : 64'd0);
    chk("pending",      64'(pending),      64'(mq.size()));
    chk("retired",      64'(retired),      64'(m_ret));
    chk("byp_hit",      64'(byp_hit),      64'(e_hit));
    chk("byp_data",     64'(byp_data),     64'(e_byp));
  endtask

  // Called just after a falling edge: drive, check, advance the model across the next rising edge
  task automatic step(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                      input logic [WORD-1:0] alu, input logic [WORD-1:0] mem,
                      input logic ack, input logic [4:0] br);
    logic do_push, do_pop;
    ent_t e;
    in_valid = v; reg_write_in = rw; mem_to_reg = m2r; dest_reg = rd;
    alu_result = alu; mem_data = mem; wb_ack = ack; byp_reg = br;
    #1;
    check_all();
    do_pop  = ack && (mq.size() > 0);
    do_push = v && (mq.size() < DEPTH) && rw && (rd != 5'd31);
    if (do_pop) begin
      void'(mq.pop_front());
      if (m_ret != 32'hFFFF) m_ret++;
    end
    if (do_push) begin
      e.r = rd;
      e.d = m2r ? mem : alu;
      mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic peek();
    in_valid = 1'b0;
    wb_ack   = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; reg_write_in = 0; mem_to_reg = 0; dest_reg = 0;
    alu_result = 0; mem_data = 0; wb_ack = 0; byp_reg = 0;
    mq.delete();
    m_ret = 0;
    #2;
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
    chk("rst_wb_register", 64'(wb_register), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: ALU result to X3
    step(1, 1, 0, 5'd3, 64'h11, 64'h99, 0, 5'd0);
    peek();
    chk("t1_wb_reg_write", 64'(wb_reg_write), 64'd1);
    chk("t1_wb_register", 64'(wb_register), 64'd3);
    chk("t1_wb_data", 64'(wb_data), 64'h11);
    step(0, 0, 0, 5'd0, 64'h0, 64'h0, 1, 5'd0);
    peek();
    chk("t1_pending", 64'(pending), 64'd0);
    chk("t1_retired", 64'(retired), 64'd1);

    // Scenario 2: load data selected
    step(1, 1, 1, 5'd5, 64'h77, 64'hDEAD, 0, 5'd5);
    peek();
    chk("t2_wb_data", 64'(wb_data), 64'hDEAD);
    chk("t2_byp_data", 64'(byp_data), 64'hDEAD);
    step(0, 0, 0, 5'd0, 64'h0, 64'h0, 1, 5'd0);

    // Scenario 3: XZR and non-writing results vanish
    step(1, 1, 0, 5'd31, 64'h5, 64'h0, 0, 5'd31);
    step(1, 0, 0, 5'd4, 64'h6, 64'h0, 0, 5'd4);
    peek();
    chk("t3_pending", 64'(pending), 64'd0);
    chk("t3_wb_reg_write", 64'(wb_reg_write), 64'd0);

    // Scenario 4: full queue backpressure, drain order
    step(1, 1, 0, 5'd1, 64'hA1, 64'h0, 0, 5'd0);
    step(1, 1, 0, 5'd2, 64'hA2, 64'h0, 0, 5'd0);
    peek();
    chk("t4_in_ready_full", 64'(in_ready), 64'd0);
    step(1, 1, 0, 5'd3, 64'hA3, 64'h0, 1, 5'd0);
    peek();
    chk("t4_pending_after_ack", 64'(pending), 64'd1);
    chk("t4_head_second", 64'(wb_data), 64'hA2);
    step(1, 1, 0, 5'd3, 64'hA3, 64'h0, 0, 5'd0);
    peek();
    chk("t4_pending_third_in", 64'(pending), 64'd2);
    step(0, 0, 0, 5'd0, 64'h0, 64'h0, 1, 5'd0);
    peek();
    chk("t4_head_third", 64'(wb_data), 64'hA3);
    step(0, 0, 0, 5'd0, 64'h0, 64'h0, 1, 5'd0);

    // Scenario 5: youngest bypass wins; XZR never hits
    step(1, 1, 0, 5'd7, 64'hA, 64'h0, 0, 5'd7);
    step(1, 1, 0, 5'd7, 64'hB, 64'h0, 0, 5'd7);
    peek();
    chk("t5_byp_hit", 64'(byp_hit), 64'd1);
    chk("t5_byp_data", 64'(byp_data), 64'hB);
    byp_reg = 5'd31;
    #1;
    chk("t5_byp_xzr", 64'(byp_hit), 64'd0);

    // Scenario 6: asynchronous reset with two entries queued
    rst_n = 1'b0;
    #1;
    chk("t6_pending", 64'(pending), 64'd0);
    chk("t6_wb_reg_write", 64'(wb_reg_write), 64'd0);
    mq.delete();
    m_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] rd, br;
      rd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      br = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
           rd, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), br);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
